pipe_seg_skid: RTL and testbench
================================

Name: pipe_seg_skid

Overview:
- Parametrised successor to the fixed ID/EX-style segment register, usable between any two core pipeline stages.
- Carries an opaque control payload plus NUM_OPND operand fields through a 2-entry (output + skid) buffer.
- Uses a valid/ready handshake, so the upstream stage sees a registered ready and the downstream stall does not propagate combinationally.
- Supports flush, per-operand late recode (forwarding patch) of the entry being presented, and an occupancy counter.

Parameters:
- PAYLOAD_W, 128, width of opaque control/payload bus (pc, inst, decoded controls).
- NUM_OPND, 2, number of independently recodable operand fields.
- OPND_W, 32, width of each operand field.
- ZERO_ON_EMPTY, 1, when 1 the output payload/operands are zeroed whenever out_valid goes low; when 0 they hold their last value.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- in_payload  in  PAYLOAD_W  upstream payload.
- in_opnd  in  NUM_OPND*OPND_W  upstream operands; field k at bits [k*OPND_W +: OPND_W].
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts (out_valid && out_ready = pop).
- out_payload  out  PAYLOAD_W  presented payload.
- out_opnd  out  NUM_OPND*OPND_W  presented operands.
- flush  in  1  discard all held entries.
- recode_en  in  NUM_OPND  per-field patch enable for the presented entry.
- recode_data  in  NUM_OPND*OPND_W  patch values, same field layout as in_opnd.
- occupancy  out  2  number of valid entries, 0..2.

Behaviour:
- State: out entry (out_valid, payload, opnd), skid entry (skid_valid, payload, opnd). All transfers take 1 cycle.
- Reset or flush (reset dominates; flush is identical in effect):
  - out_valid = skid_valid = 0.
  - Payload and operand registers are zeroed regardless of ZERO_ON_EMPTY.
  - in_ready = 1 the next cycle, occupancy = 0.
  - Any input fire or recode in that cycle is dropped.
- Flush and the handshake: flush ignores the handshake. A pop asserted in the same cycle still completes from the downstream view, but nothing new is loaded.
- Accept: in_fire = in_valid && in_ready.
- Case out empty:
  - in_fire loads the out entry; out_valid = 1 next cycle.
  - The skid entry is never valid in this state (invariant, asserted in verification).
- Case out valid and pop, with priority skid > input:
  - skid_valid: skid moves to out, skid_valid = 0.
  - Else if in_fire: input moves to out.
  - Else: out_valid = 0; zero out regs if ZERO_ON_EMPTY = 1.
- Case out valid, no pop:
  - in_fire loads the skid entry, skid_valid = 1.
  - Since in_ready = !skid_valid, a full skid cannot overflow.
- Recode, for each field k:
  - If recode_en[k] && out_valid && !pop && !flush, out_opnd field k <= recode_data field k.
  - Other fields and the payload are untouched.
  - Recode never touches the skid entry or an incoming entry. The issuing forwarding logic re-evaluates after a shift.
  - Recode during a pop is ignored; the new entry loads as normal.
  - Recode with out_valid = 0 is ignored.
- occupancy = out_valid + skid_valid, registered alongside state.
- No combinational path from out_ready or recode_* to in_ready.
- Throughput: 1 entry/cycle when out_ready is held high. Latency is in_fire to out_valid = 1 cycle.

Decomposition:
- Shared header (head.vh) holds the default PAYLOAD_W/OPND_W constants per pipeline boundary and the operand field index names (OPND_RS = 0, OPND_RT = 1).
- One sub-module: seg_opnd_patch, a combinational per-field mux applying recode_en/recode_data to an operand vector. It is instantiated once on the out entry.

Test Plan:
- Reset and flush:
  - Assert reset 2 cycles with in_valid = 1 and payload 0xAA.. → out_valid = 0, out_payload = 0, out_opnd = 0, occupancy = 0, in_ready = 1 after release.
  - Flush with occupancy = 2 → occupancy = 0 next cycle, in_ready = 1, no stale entry ever popped.
- Streaming: out_ready = 1, push operand pairs (0x1, 0x2), (0x3, 0x4), (0x5, 0x6) on consecutive cycles → same order on out one cycle later each; occupancy never exceeds 1.
- Backpressure: hold out_ready = 0, push A then B → A presented, B in skid, in_ready = 0, occupancy = 2. Release out_ready → A then B popped on consecutive cycles, in_ready back to 1 after the first pop.
- Recode:
  - Stalled entry with opnd0 = 0x10, opnd1 = 0x20; recode_en = 2'b10, recode_data = {0xBEEF, 0x0} → out_opnd1 = 0xBEEF, opnd0 still 0x10, payload unchanged.
  - Same recode issued in a pop cycle → ignored; next entry intact.
- ZERO_ON_EMPTY:
  - =1: pop last entry (payload 0x55) with no input → out_payload = 0.
  - =0: same stimulus → out_payload stays 0x55 with out_valid = 0.

Source files
------------

// File: rtl/pipe_seg_skid_pkg.sv
// rtl/pipe_seg_skid_pkg.sv - shared constants, operand field names and occupancy state for the pipeline segment
package pipe_seg_skid_pkg;

    // Default widths at the decode/execute boundary.
    localparam int DEF_PAYLOAD_W = 128;
    localparam int DEF_NUM_OPND  = 2;
    localparam int DEF_OPND_W    = 32;

    // Operand field indices within the operand vector.
    localparam int OPND_RS = 0;
    localparam int OPND_RT = 1;

    // The encoding doubles as the occupancy count:
    // ONE means out entry only, TWO means out and skid entries both held.
    typedef enum logic [1:0] {
        SEG_EMPTY = 2'd0,
        SEG_ONE   = 2'd1,
        SEG_TWO   = 2'd2
    } seg_state_t;

endpackage

// File: rtl/pipe_seg_skid_if.sv
// rtl/pipe_seg_skid_if.sv - upstream/downstream valid-ready bundle for the pipeline segment
//   master: environment side (drives in_valid/in_payload/in_opnd/out_ready)
//   slave : segment side (drives in_ready/out_valid/out_payload/out_opnd)
interface pipe_seg_skid_if
    import pipe_seg_skid_pkg::*;
#(
    parameter int PAYLOAD_W = DEF_PAYLOAD_W,
    parameter int NUM_OPND  = DEF_NUM_OPND,
    parameter int OPND_W    = DEF_OPND_W
) ();

    logic                         in_valid;
    logic                         in_ready;
    logic [PAYLOAD_W-1:0]         in_payload;
    logic [NUM_OPND*OPND_W-1:0]   in_opnd;
    logic                         out_valid;
    logic                         out_ready;
    logic [PAYLOAD_W-1:0]         out_payload;
    logic [NUM_OPND*OPND_W-1:0]   out_opnd;

    modport master (
        output in_valid, in_payload, in_opnd, out_ready,
        input  in_ready, out_valid, out_payload, out_opnd
    );

    modport slave (
        input  in_valid, in_payload, in_opnd, out_ready,
        output in_ready, out_valid, out_payload, out_opnd
    );

endinterface

// File: rtl/pipe_seg_skid_opnd_patch.sv
// rtl/pipe_seg_skid_opnd_patch.sv - combinational per-field operand recode mux
//   opnd_in  : operand vector, field k at [k*OPND_W +: OPND_W]
//   patch_en : per-field replace enable
//   patch_data: replacement values, same layout as opnd_in
//   opnd_out : opnd_in with enabled fields replaced
module seg_opnd_patch #(
    parameter int NUM_OPND = 2,
    parameter int OPND_W   = 32
) (
    input  logic [NUM_OPND*OPND_W-1:0] opnd_in,
    input  logic [NUM_OPND-1:0]        patch_en,
    input  logic [NUM_OPND*OPND_W-1:0] patch_data,
    output logic [NUM_OPND*OPND_W-1:0] opnd_out
);

    always_comb begin
        opnd_out = opnd_in;
        for (int k = 0; k < NUM_OPND; k++) begin
            if (patch_en[k]) begin
                opnd_out[k*OPND_W +: OPND_W] = patch_data[k*OPND_W +: OPND_W];
            end
        end
    end

endmodule

// File: rtl/pipe_seg_skid.sv
// rtl/pipe_seg_skid.sv - 2-entry (out + skid) pipeline segment register with flush, operand recode and occupancy
//   clk, reset  : clock, synchronous active-high reset
//   bus         : upstream in_* / downstream out_* valid-ready handshake (slave side)
//   flush       : discard both held entries, same effect as reset
//   recode_en   : per-operand patch enable for the presented, stalled entry
//   recode_data : patch values, same field layout as the operand vector
//   occupancy   : number of held entries, 0..2
module pipe_seg_skid
    import pipe_seg_skid_pkg::*;
#(
    parameter int PAYLOAD_W     = DEF_PAYLOAD_W,
    parameter int NUM_OPND      = DEF_NUM_OPND,
    parameter int OPND_W        = DEF_OPND_W,
    parameter bit ZERO_ON_EMPTY = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    pipe_seg_skid_if.slave             bus,
    input  logic                       flush,
    input  logic [NUM_OPND-1:0]        recode_en,
    input  logic [NUM_OPND*OPND_W-1:0] recode_data,
    output logic [1:0]                 occupancy
);

    localparam int OV_W = NUM_OPND * OPND_W;

    seg_state_t           state_q, state_d;
    logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;
    logic [OV_W-1:0]      out_opnd_q,    out_opnd_d;
    logic [PAYLOAD_W-1:0] skid_payload_q, skid_payload_d;
    logic [OV_W-1:0]      skid_opnd_q,    skid_opnd_d;

    logic            out_valid;
    logic            in_ready;
    logic            pop;
    logic            in_fire;
    logic [OV_W-1:0] out_opnd_patched;

    // in_ready and out_valid depend only on the state register, so neither
    // out_ready nor recode_* can reach in_ready combinationally.
    assign out_valid = (state_q != SEG_EMPTY);
    assign in_ready  = (state_q != SEG_TWO);
    assign pop       = out_valid && bus.out_ready;
    assign in_fire   = bus.in_valid && in_ready;

    // The patched vector is only committed in the stalled (no-pop) branches
    // below, which is what confines recode to the presented entry.
    seg_opnd_patch #(
        .NUM_OPND (NUM_OPND),
        .OPND_W   (OPND_W)
    ) u_patch (
        .opnd_in    (out_opnd_q),
        .patch_en   (recode_en),
        .patch_data (recode_data),
        .opnd_out   (out_opnd_patched)
    );

    always_comb begin
        state_d        = state_q;
        out_payload_d  = out_payload_q;
        out_opnd_d     = out_opnd_q;
        skid_payload_d = skid_payload_q;
        skid_opnd_d    = skid_opnd_q;

        case (state_q)
            SEG_EMPTY: begin
                if (in_fire) begin
                    out_payload_d = bus.in_payload;
                    out_opnd_d    = bus.in_opnd;
                    state_d       = SEG_ONE;
                end
            end
            SEG_ONE: begin
                if (pop) begin
                    if (in_fire) begin
                        out_payload_d = bus.in_payload;
                        out_opnd_d    = bus.in_opnd;
                    end else begin
                        state_d = SEG_EMPTY;
                        if (ZERO_ON_EMPTY) begin
                            out_payload_d = '0;
                            out_opnd_d    = '0;
                        end
                    end
                end else begin
                    out_opnd_d = out_opnd_patched;
                    if (in_fire) begin
                        skid_payload_d = bus.in_payload;
                        skid_opnd_d    = bus.in_opnd;
                        state_d        = SEG_TWO;
                    end
                end
            end
            SEG_TWO: begin
                // in_ready is low here, so only the skid entry can refill out.
                if (pop) begin
                    out_payload_d  = skid_payload_q;
                    out_opnd_d     = skid_opnd_q;
                    skid_payload_d = '0;
                    skid_opnd_d    = '0;
                    state_d        = SEG_ONE;
                end else begin
                    out_opnd_d = out_opnd_patched;
                end
            end
            default: begin
                state_d = SEG_EMPTY;
            end
        endcase

        // Flush wins over any load or recode computed above; a concurrent pop
        // still completes downstream because out_valid was high this cycle.
        if (flush) begin
            state_d        = SEG_EMPTY;
            out_payload_d  = '0;
            out_opnd_d     = '0;
            skid_payload_d = '0;
            skid_opnd_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= SEG_EMPTY;
            out_payload_q  <= '0;
            out_opnd_q     <= '0;
            skid_payload_q <= '0;
            skid_opnd_q    <= '0;
        end else begin
            state_q        <= state_d;
            out_payload_q  <= out_payload_d;
            out_opnd_q     <= out_opnd_d;
            skid_payload_q <= skid_payload_d;
            skid_opnd_q    <= skid_opnd_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_payload = out_payload_q;
    assign bus.out_opnd    = out_opnd_q;
    assign occupancy       = state_q;

endmodule

// File: tb/tb_pipe_seg_skid.sv
// tb/tb_pipe_seg_skid.sv - directed self-checking bench for pipe_seg_skid (ZERO_ON_EMPTY 1 and 0 side by side)
module tb_pipe_seg_skid;

    localparam int PW = 128;
    localparam int NO = 2;
    localparam int OW = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic [NO-1:0]    recode_en;
    logic [NO*OW-1:0] recode_data;
    logic             in_valid;
    logic [PW-1:0]    in_payload;
    logic [NO*OW-1:0] in_opnd;
    logic             out_ready;
    logic [1:0]       occ1, occ0;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    pipe_seg_skid_if #(.PAYLOAD_W(PW), .NUM_OPND(NO), .OPND_W(OW)) if1 ();
    pipe_seg_skid_if #(.PAYLOAD_W(PW), .NUM_OPND(NO), .OPND_W(OW)) if0 ();

    assign if1.in_valid   = in_valid;
    assign if1.in_payload = in_payload;
    assign if1.in_opnd    = in_opnd;
    assign if1.out_ready  = out_ready;
    assign if0.in_valid   = in_valid;
    assign if0.in_payload = in_payload;
    assign if0.in_opnd    = in_opnd;
    assign if0.out_ready  = out_ready;

    pipe_seg_skid #(.PAYLOAD_W(PW), .NUM_OPND(NO), .OPND_W(OW), .ZERO_ON_EMPTY(1'b1)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .bus         (if1.slave),
        .flush       (flush),
        .recode_en   (recode_en),
        .recode_data (recode_data),
        .occupancy   (occ1)
    );

    pipe_seg_skid #(.PAYLOAD_W(PW), .NUM_OPND(NO), .OPND_W(OW), .ZERO_ON_EMPTY(1'b0)) dut0 (
        .clk         (clk),
        .reset       (reset),
        .bus         (if0.slave),
        .flush       (flush),
        .recode_en   (recode_en),
        .recode_data (recode_data),
        .occupancy   (occ0)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [PW-1:0] p, input logic [OW-1:0] o1, input logic [OW-1:0] o0);
        in_valid   = 1'b1;
        in_payload = p;
        in_opnd    = {o1, o0};
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        recode_en   = '0;
        recode_data = '0;
        out_ready   = 1'b0;
        push({16{8'hAA}}, 32'hAAAA_AAAA, 32'hAAAA_AAAA);

        // Reset held two cycles with a valid input offered
        tick(); tick();
        chk("rst_out_valid", if1.out_valid, 0);
        chk("rst_payload",   if1.out_payload, 0);
        chk("rst_opnd",      if1.out_opnd, 0);
        chk("rst_occ",       occ1, 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("post_rst_out_valid", if1.out_valid, 0);
        chk("post_rst_payload",   if1.out_payload, 0);
        chk("post_rst_opnd",      if1.out_opnd, 0);
        chk("post_rst_occ",       occ1, 0);
        chk("post_rst_in_ready",  if1.in_ready, 1);

        // Recode while empty is ignored
        recode_en   = 2'b11;
        recode_data = {32'h1234, 32'h5678};
        tick();
        chk("recode_empty_opnd",  if1.out_opnd, 0);
        chk("recode_empty_valid", if1.out_valid, 0);
        recode_en = '0;

        // Streaming with out_ready held high
        out_ready = 1'b1;
        push(128'h101, 32'h2, 32'h1);
        tick();
        chk("strm0_valid", if1.out_valid, 1);
        chk("strm0_opnd",  if1.out_opnd, {32'h2, 32'h1});
        chk("strm0_occ",   occ1, 1);
        push(128'h102, 32'h4, 32'h3);
        tick();
        chk("strm1_opnd",  if1.out_opnd, {32'h4, 32'h3});
        chk("strm1_pay",   if1.out_payload, 128'h102);
        chk("strm1_occ",   occ1, 1);
        push(128'h103, 32'h6, 32'h5);
        tick();
        chk("strm2_opnd",  if1.out_opnd, {32'h6, 32'h5});
        chk("strm2_occ",   occ1, 1);
        chk("strm2_rdy",   if1.in_ready, 1);
        in_valid = 1'b0;
        tick();
        chk("strm_drain_valid", if1.out_valid, 0);
        chk("strm_drain_occ",   occ1, 0);
        chk("strm_drain_z1",    if1.out_payload, 0);
        chk("strm_drain_z0",    if0.out_payload, 128'h103);

        // Backpressure: A presented, B into skid
        out_ready = 1'b0;
        push(128'hA, 32'h20, 32'h10);
        tick();
        chk("bp_a_occ",   occ1, 1);
        chk("bp_a_rdy",   if1.in_ready, 1);
        push(128'hB, 32'h22, 32'h21);
        tick();
        chk("bp_b_occ",   occ1, 2);
        chk("bp_b_rdy",   if1.in_ready, 0);
        chk("bp_b_pay",   if1.out_payload, 128'hA);
        in_valid = 1'b0;

        // Recode of the stalled entry: only field 1 changes
        recode_en   = 2'b10;
        recode_data = {32'hBEEF, 32'h0};
        tick();
        chk("rc_opnd", if1.out_opnd, {32'hBEEF, 32'h10});
        chk("rc_pay",  if1.out_payload, 128'hA);
        chk("rc_occ",  occ1, 2);

        // Same recode in a pop cycle: B arrives untouched
        out_ready = 1'b1;
        tick();
        chk("pop_a_pay",  if1.out_payload, 128'hB);
        chk("pop_a_opnd", if1.out_opnd, {32'h22, 32'h21});
        chk("pop_a_occ",  occ1, 1);
        chk("pop_a_rdy",  if1.in_ready, 1);
        recode_en = '0;
        tick();
        chk("pop_b_valid", if1.out_valid, 0);
        chk("pop_b_occ",   occ1, 0);

        // Flush at occupancy 2, with a pop and a new input in the same cycle
        out_ready = 1'b0;
        push(128'hC, 32'hC1, 32'hC0);
        tick();
        push(128'hD, 32'hD1, 32'hD0);
        tick();
        chk("fl_pre_occ", occ1, 2);
        flush     = 1'b1;
        out_ready = 1'b1;
        push(128'hE, 32'hE1, 32'hE0);
        recode_en = 2'b11;
        tick();
        chk("fl_occ",   occ1, 0);
        chk("fl_rdy",   if1.in_ready, 1);
        chk("fl_valid", if1.out_valid, 0);
        chk("fl_pay0",  if0.out_payload, 0);
        chk("fl_opnd0", if0.out_opnd, 0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        recode_en = '0;
        tick();
        chk("fl_post_valid", if1.out_valid, 0);
        chk("fl_post_occ0",  occ0, 0);

        // Pop of last entry with no input: zeroed vs held
        out_ready = 1'b0;
        push(128'h55, 32'h0, 32'h0);
        tick();
        chk("z_pre_pay", if0.out_payload, 128'h55);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("z1_valid", if1.out_valid, 0);
        chk("z1_pay",   if1.out_payload, 0);
        chk("z0_valid", if0.out_valid, 0);
        chk("z0_pay",   if0.out_payload, 128'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
